lookup_cfg_ctrl: RTL
====================

# lookup_cfg_ctrl

Control-plane sequencer that installs one match-action entry per request into a pipeline stage's lookup engine: action RAM word, then CAM key/mask entry. Sits between the stage's configuration input and the lookup engine's write ports. Pauses the key extractor and drains in-flight lookups so no lookup sees a half-written entry. Waits for the CAM write to retire before reporting completion.

## Interface
Parameters:
- STAGE, 0: stage index this instance owns; requests for other stages are discarded.
- KEY_LEN, 197: CAM key/mask width.
- ACT_LEN, 25: action slot width; action word is ACT_LEN*25 bits.
- DEPTH, 16: entries in CAM and action RAM.
- ADDR_W, 4: entry address width (log2 DEPTH).
- DRAIN, 4: cycles a lookup occupies the engine after key_valid.
- TIMEOUT, 64: max cycles to wait for cam_busy to clear.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  request valid.
- cfg_ready  out  1  request accepted when high with cfg_valid.
- cfg_stage  in  4  target stage.
- cfg_addr  in  ADDR_W  entry index.
- cfg_key  in  KEY_LEN  CAM key.
- cfg_mask  in  KEY_LEN  CAM mask; bit=1 is don't-care, passed through unchanged.
- cfg_action  in  ACT_LEN*25  action word.
- cfg_done  out  1  one-cycle completion pulse.
- cfg_err  out  1  valid with cfg_done; 1 = CAM busy timeout.
- key_valid  in  1  extractor key strobe, monitored for in-flight tracking.
- lkup_hold  out  1  to extractor: hold off new keys.
- lookup_din  out  KEY_LEN  CAM write data.
- lookup_din_mask  out  KEY_LEN  CAM write mask.
- lookup_din_addr  out  ADDR_W  CAM write address.
- lookup_din_en  out  1  CAM write enable.
- cam_busy  in  1  CAM write-in-progress.
- action_data_in  out  ACT_LEN*25  action RAM write data.
- action_addr  out  ADDR_W  action RAM write address.
- action_en  out  1  action RAM write enable.

## Operation
- All outputs registered. Reset: cfg_ready=0 (1 from first cycle after reset release), cfg_done=0, cfg_err=0, lkup_hold=0, lookup_din_en=0, action_en=0, all data/address outputs 0, drain_cnt=0, state IDLE.
- Request fields captured into internal registers on accept; inputs may change afterwards.
- drain_cnt: loaded with DRAIN on any cycle key_valid=1 (any state), else decrements saturating at 0.
- States:
  - IDLE: cfg_ready=1. On accept with cfg_stage==STAGE -> HOLD. On accept with cfg_stage!=STAGE: request dropped, stays IDLE, no done pulse, cfg_ready=0 for the following cycle.
  - HOLD: lkup_hold=1. Exit to WR_ACT when drain_cnt==0 and key_valid==0; otherwise stay.
  - WR_ACT: action_en=1, action_addr/action_data_in = captured addr/action. -> WR_CAM.
  - WR_CAM: lookup_din_en=1, lookup_din/mask/addr = captured values. -> WAIT_BUSY.
  - WAIT_BUSY: timer counts from 0. Exit to DONE when timer>=1 and cam_busy==0 (err=0), or timer==TIMEOUT-1 with cam_busy==1 (err=1).
  - DONE: cfg_done=1, cfg_err per exit cause, lkup_hold=1. -> IDLE.
- Data/address outputs hold last written values between writes; enables are single-cycle.
- lkup_hold asserted from the cycle after accept through DONE inclusive.

## Timing
- Accept at cycle T; no in-flight lookups; cam_busy low: HOLD T+1, action_en T+2, lookup_din_en T+3, WAIT_BUSY T+4..T+5, cfg_done T+6, IDLE with cfg_ready=1 and lkup_hold=0 at T+7. Minimum turnaround 7 cycles.
- key_valid at T (same cycle as accept): drain_cnt=DRAIN at T+1; WR_ACT no earlier than T+DRAIN+2.
- key_valid while lkup_hold=1 (extractor violation): tolerated, drain restarts, write postponed.
- cam_busy high through WAIT_BUSY: cfg_done with cfg_err=1 exactly TIMEOUT cycles after entering WAIT_BUSY.
- Reset mid-sequence: immediate return to reset values; partially written entry is not rolled back; upper layer must rewrite.
- cfg_addr wrap: none; ADDR_W covers DEPTH exactly.

## Test plan
- Idle install: STAGE=0, request stage 0, addr 5, key 197'h1ABC, mask 0, action 625'h3f; no traffic -> action_en at T+2 addr 5, lookup_din_en at T+3 addr 5 key 1ABC, cfg_done at T+6, cfg_err=0.
- Drain: key_valid at T-1 and T -> no enable before T+6; cfg_done exactly 4 cycles later than idle case.
- Stage mismatch: cfg_stage=3 -> cfg_ready low one cycle, no enables, no done, lkup_hold stays 0.
- Busy wait: cam_busy high T+4..T+9 -> cfg_done at T+11, cfg_err=0; timeout: cam_busy stuck high, TIMEOUT=64 -> cfg_done with cfg_err=1 at T+68.
- Back-to-back: cfg_valid held with two requests (addr 1, addr 2) -> second accepted at T+7, both entries written in order, two done pulses 7 cycles apart.
- Reset in WR_CAM: rst_n low at T+3 -> all outputs 0 asynchronously, cfg_ready=1 after release, new request completes normally.

Source files
------------

// File: rtl/lookup_cfg_ctrl.sv
// lookup_cfg_ctrl: installs one match-action entry per accepted request.
// Sequence: pause the key extractor, wait for in-flight lookups to drain,
// write the action RAM word, write the CAM key/mask, then wait for the CAM
// write to retire (or time out) before pulsing cfg_done.
module lookup_cfg_ctrl #(
  parameter int STAGE   = 0,
  parameter int KEY_LEN = 197,
  parameter int ACT_LEN = 25,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int DRAIN   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [3:0]             cfg_stage,
  input  logic [ADDR_W-1:0]      cfg_addr,
  input  logic [KEY_LEN-1:0]     cfg_key,
  input  logic [KEY_LEN-1:0]     cfg_mask,
  input  logic [ACT_LEN*25-1:0]  cfg_action,
  output logic                   cfg_done,
  output logic                   cfg_err,
  input  logic                   key_valid,
  output logic                   lkup_hold,
  output logic [KEY_LEN-1:0]     lookup_din,
  output logic [KEY_LEN-1:0]     lookup_din_mask,
  output logic [ADDR_W-1:0]      lookup_din_addr,
  output logic                   lookup_din_en,
  input  logic                   cam_busy,
  output logic [ACT_LEN*25-1:0]  action_data_in,
  output logic [ADDR_W-1:0]      action_addr,
  output logic                   action_en
);

  localparam int ACT_W = ACT_LEN * 25;
  localparam int DRN_W = $clog2(DRAIN + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] HOLD      = 3'd1;
  localparam logic [2:0] WR_ACT    = 3'd2;
  localparam logic [2:0] WR_CAM    = 3'd3;
  localparam logic [2:0] WAIT_BUSY = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  // Named scope that only exists when the address width does not span the
  // table exactly; addresses are never wrapped, so such a build is suspect.
  if (DEPTH != (1 << ADDR_W)) begin : g_depth_addr_mismatch
  end

  logic [2:0]         state_reg, state_next;
  logic [DRN_W-1:0]   drain_cnt_reg;
  logic [TMR_W-1:0]   timer_reg;
  logic               timeout_hit;
  logic               accept;
  logic               stage_match;

  logic [ADDR_W-1:0]  cap_addr_reg;
  logic [KEY_LEN-1:0] cap_key_reg;
  logic [KEY_LEN-1:0] cap_mask_reg;
  logic [ACT_W-1:0]   cap_action_reg;

  logic               cfg_ready_reg, cfg_done_reg, cfg_err_reg, lkup_hold_reg;
  logic               lookup_din_en_reg, action_en_reg;
  logic [KEY_LEN-1:0] lookup_din_reg, lookup_din_mask_reg;
  logic [ADDR_W-1:0]  lookup_din_addr_reg, action_addr_reg;
  logic [ACT_W-1:0]   action_data_reg;

  // cfg_ready is only ever high in IDLE, so a handshake implies IDLE.
  assign accept      = cfg_valid && cfg_ready_reg;
  assign stage_match = (cfg_stage == 4'(STAGE));

  // Next-state logic; timeout_hit marks the busy-timeout exit of WAIT_BUSY.
  always_comb begin
    state_next  = state_reg;
    timeout_hit = 1'b0;
    case (state_reg)
      IDLE:      if (accept && stage_match) state_next = HOLD;
      HOLD:      if (drain_cnt_reg == '0 && !key_valid) state_next = WR_ACT;
      WR_ACT:    state_next = WR_CAM;
      WR_CAM:    state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (timer_reg != '0 && !cam_busy) begin
          state_next = DONE;
        end else if (cam_busy && timer_reg == TMR_W'(TIMEOUT - 1)) begin
          state_next  = DONE;
          timeout_hit = 1'b1;
        end
      end
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // In-flight lookup tracker: every key restarts the full drain window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    drain_cnt_reg <= '0;
    else if (key_valid)            drain_cnt_reg <= DRN_W'(DRAIN);
    else if (drain_cnt_reg != '0)  drain_cnt_reg <= drain_cnt_reg - DRN_W'(1);
  end

  // CAM busy timer: zero on entry to WAIT_BUSY, counts while there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      timer_reg <= '0;
    else if (state_reg == WAIT_BUSY) timer_reg <= timer_reg + TMR_W'(1);
    else                             timer_reg <= '0;
  end

  // Capture the request so the requester may move on after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_addr_reg   <= '0;
      cap_key_reg    <= '0;
      cap_mask_reg   <= '0;
      cap_action_reg <= '0;
    end else if (accept && stage_match) begin
      cap_addr_reg   <= cfg_addr;
      cap_key_reg    <= cfg_key;
      cap_mask_reg   <= cfg_mask;
      cap_action_reg <= cfg_action;
    end
  end

  // Registered outputs decoded from the next state; data holds between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready_reg       <= 1'b0;
      cfg_done_reg        <= 1'b0;
      cfg_err_reg         <= 1'b0;
      lkup_hold_reg       <= 1'b0;
      action_en_reg       <= 1'b0;
      action_addr_reg     <= '0;
      action_data_reg     <= '0;
      lookup_din_en_reg   <= 1'b0;
      lookup_din_addr_reg <= '0;
      lookup_din_reg      <= '0;
      lookup_din_mask_reg <= '0;
    end else begin
      cfg_ready_reg     <= (state_next == IDLE) && !accept;
      cfg_done_reg      <= (state_next == DONE);
      cfg_err_reg       <= timeout_hit;
      lkup_hold_reg     <= (state_next != IDLE);
      action_en_reg     <= (state_next == WR_ACT);
      lookup_din_en_reg <= (state_next == WR_CAM);
      if (state_next == WR_ACT) begin
        action_addr_reg <= cap_addr_reg;
        action_data_reg <= cap_action_reg;
      end
      if (state_next == WR_CAM) begin
        lookup_din_addr_reg <= cap_addr_reg;
        lookup_din_reg      <= cap_key_reg;
        lookup_din_mask_reg <= cap_mask_reg;
      end
    end
  end

  assign cfg_ready       = cfg_ready_reg;
  assign cfg_done        = cfg_done_reg;
  assign cfg_err         = cfg_err_reg;
  assign lkup_hold       = lkup_hold_reg;
  assign action_en       = action_en_reg;
  assign action_addr     = action_addr_reg;
  assign action_data_in  = action_data_reg;
  assign lookup_din_en   = lookup_din_en_reg;
  assign lookup_din_addr = lookup_din_addr_reg;
  assign lookup_din      = lookup_din_reg;
  assign lookup_din_mask = lookup_din_mask_reg;

endmodule
